icache_assoc: RTL

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin replacement and an L2 line-fill port.
// Optional hit/miss statistics outputs are enabled with the ICACHE_STATS_EN macro.
module icache_assoc #(
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 8,
  parameter int WORD_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        flush,
  output logic        flush_done,
  output logic        l2_req,
  output logic [31:0] l2_addr,
  input  logic        l2_gnt,
  input  logic        l2_rvalid,
  input  logic [31:0] l2_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int          TAG_W = 32 - SET_BITS - WORD_BITS - 2;
  localparam int unsigned SETS  = 1 << SET_BITS;
  localparam int unsigned WORDS = 1 << WORD_BITS;
  localparam int          WAY_W = $clog2(WAYS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_MISS_REQ, ST_REFILL, ST_FLUSH
  } state_t;

  state_t               r_state;
  logic [31:2]          r_addr;
  logic [WAYS-1:0]      r_valid [SETS];
  logic [WAY_W-1:0]     r_rr    [SETS];
  logic [TAG_W-1:0]     r_tag   [WAYS][SETS];
  logic [31:0]          r_data  [WAYS][SETS][WORDS];
  logic [WAY_W-1:0]     r_victim;
  logic                 r_vic_rr;
  logic [WORD_BITS-1:0] r_beat;
  logic                 r_relook;
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_data;
  logic                 r_flush_done;
  logic                 r_l2_req;
  logic [31:0]          r_l2_addr;

  logic [TAG_W-1:0]     w_tag;
  logic [SET_BITS-1:0]  w_idx;
  logic [WORD_BITS-1:0] w_off;
  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic                 w_inv;
  logic [WAY_W-1:0]     w_inv_way;
  logic                 w_beat_we;
  logic                 w_last_beat;
  logic                 w_unused;

  assign w_tag       = r_addr[31 -: TAG_W];
  assign w_idx       = r_addr[WORD_BITS+2 +: SET_BITS];
  assign w_off       = r_addr[2 +: WORD_BITS];
  assign w_beat_we   = (r_state == ST_REFILL) && l2_rvalid;
  assign w_last_beat = &r_beat;
  assign w_unused    = ^req_addr[1:0];

  // Gated with rst so the handshake reads low while reset is held.
  assign req_ready  = rst && (r_state == ST_IDLE) && !flush;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign flush_done = r_flush_done;
  assign l2_req     = r_l2_req;
  assign l2_addr    = r_l2_addr;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!w_hit && r_valid[w_idx][i] && (r_tag[i][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
      if (!w_inv && !r_valid[w_idx][i]) begin
        w_inv     = 1'b1;
        w_inv_way = WAY_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat_we) r_data[r_victim][w_idx][r_beat] <= l2_rdata;
    if (w_beat_we && w_last_beat) r_tag[r_victim][w_idx] <= w_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_victim     <= '0;
      r_vic_rr     <= 1'b0;
      r_beat       <= '0;
      r_relook     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_flush_done <= 1'b0;
      r_l2_req     <= 1'b0;
      r_l2_addr    <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
`ifdef ICACHE_STATS_EN
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
`endif
    end else begin
      r_rsp_valid  <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_flush_done <= 1'b1;
            r_state      <= ST_FLUSH;
          end else if (req_valid) begin
            r_addr   <= req_addr[31:2];
            r_relook <= 1'b0;
            r_state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_data[w_hit_way][w_idx][w_off];
            r_state     <= ST_IDLE;
`ifdef ICACHE_STATS_EN
            if (!r_relook) r_hit_cnt <= r_hit_cnt + 32'd1;
`endif
          end else begin
            r_victim  <= w_inv ? w_inv_way : r_rr[w_idx];
            r_vic_rr  <= !w_inv;
            r_beat    <= '0;
            r_l2_req  <= 1'b1;
            r_l2_addr <= {r_addr[31:WORD_BITS+2], {(WORD_BITS+2){1'b0}}};
            r_state   <= ST_MISS_REQ;
`ifdef ICACHE_STATS_EN
            r_miss_cnt <= r_miss_cnt + 32'd1;
`endif
          end
        end
        ST_MISS_REQ: begin
          if (l2_gnt) begin
            r_l2_req <= 1'b0;
            r_state  <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (l2_rvalid) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_valid[w_idx][r_victim] <= 1'b1;
              // WAYS is a power of two, so natural wrap is modulo WAYS.
              if (r_vic_rr) r_rr[w_idx] <= r_rr[w_idx] + 1'b1;
              r_relook <= 1'b1;
              r_state  <= ST_LOOKUP;
            end
          end
        end
        ST_FLUSH: begin
          for (int unsigned s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_rr[s]    <= '0;
          end
`ifdef ICACHE_STATS_EN
          r_hit_cnt  <= '0;
          r_miss_cnt <= '0;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
